// File: rtl/fsm_calculator_nd.sv
// fsm_calculator_nd: multi-digit keypad calculator FSM with chaining, repeat-equal and an iterative divider.
// Optional feature macro CALC_MOD_EN: accepts opcode 5 (MOD) and returns the divider remainder.
module fsm_calculator_nd #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             num_valid,
  input  logic [3:0]       button_num,
  input  logic             op_valid,
  input  logic [2:0]       button_op,
  input  logic             equal,
  output logic [WIDTH-1:0] result_temp,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             error
);
  localparam int CW = $clog2(WIDTH);
  localparam int DW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTER_A, S_ENTER_B, S_EXEC, S_DONE, S_ERROR
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_MUL = 3'd3, OP_DIV = 3'd4, OP_MOD = 3'd5
  } op_e;

  state_e           state, state_d;
  op_e              op, op_d, pend_op, pend_op_d, in_op;
  logic [WIDTH-1:0] a, a_d, b, b_d, rep_b, rep_b_d;
  logic [WIDTH-1:0] div_q, div_q_d, div_r, div_r_d;
  logic [WIDTH-1:0] result_d, result_temp_d;
  logic             result_valid_d, error_d, eq_cmt, eq_cmt_d;
  logic [DW-1:0]    a_cnt, a_cnt_d, b_cnt, b_cnt_d;
  logic [CW-1:0]    cnt, cnt_d;

  logic             op_ok, ev_num, ev_op, ev_eq;
  logic [WIDTH-1:0] d_ext, x, y, wb_val, q_new, r_new, sub;
  logic             start, start_eq, wb, wb_err, ge;
  logic [WIDTH:0]   sum, sh;
  logic [2*WIDTH-1:0] prod;

  function automatic logic [WIDTH-1:0] append(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] d);
    return v * WIDTH'(10) + d;
  endfunction

  always_comb begin
    op_ok = 1'b0;
    case (button_op)
      3'd1, 3'd2, 3'd3, 3'd4: op_ok = 1'b1;
`ifdef CALC_MOD_EN
      3'd5: op_ok = 1'b1;
`endif
      default: op_ok = 1'b0;
    endcase
  end

  // Strobe presence (not validity) sets priority: a present higher strobe drops lower ones.
  assign ev_eq  = equal;
  assign ev_op  = op_valid && !equal && op_ok;
  assign ev_num = num_valid && !op_valid && !equal && (button_num < 4'd10);
  assign in_op  = op_e'(button_op);
  assign d_ext  = {{(WIDTH-4){1'b0}}, button_num};
  assign busy   = (state == S_EXEC);

  assign sum   = {1'b0, a} + {1'b0, b};
  assign prod  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign sh    = {div_r, div_q[WIDTH-1]};
  assign ge    = (sh >= {1'b0, b});
  assign sub   = sh[WIDTH-1:0] - b;
  assign r_new = ge ? sub : sh[WIDTH-1:0];
  assign q_new = {div_q[WIDTH-2:0], ge};

  always_comb begin
    state_d        = state;
    op_d           = op;
    pend_op_d      = pend_op;
    a_d            = a;
    b_d            = b;
    rep_b_d        = rep_b;
    a_cnt_d        = a_cnt;
    b_cnt_d        = b_cnt;
    div_q_d        = div_q;
    div_r_d        = div_r;
    cnt_d          = cnt;
    eq_cmt_d       = eq_cmt;
    result_d       = result;
    result_temp_d  = result_temp;
    result_valid_d = 1'b0;
    error_d        = error;
    start          = 1'b0;
    start_eq       = 1'b0;
    x              = a;
    y              = b;
    wb             = 1'b0;
    wb_err         = 1'b0;
    wb_val         = '0;

    case (state)
      S_IDLE, S_DONE: begin
        if (ev_eq) begin
          if (state == S_DONE && op != OP_NONE) begin
            start = 1'b1; start_eq = 1'b1; x = result; y = rep_b;
          end
        end else if (ev_op) begin
          a_d = result; op_d = in_op; b_d = '0; b_cnt_d = '0; state_d = S_ENTER_B;
        end else if (ev_num) begin
          a_d = d_ext; a_cnt_d = DW'(1); state_d = S_ENTER_A;
        end
      end
      S_ENTER_A: begin
        if (ev_eq) begin
          result_d = a; result_valid_d = 1'b1; state_d = S_DONE;
        end else if (ev_op) begin
          op_d = in_op; b_d = '0; b_cnt_d = '0; state_d = S_ENTER_B;
        end else if (ev_num && a_cnt < DW'(MAX_DIGITS)) begin
          a_d = append(a, d_ext); a_cnt_d = a_cnt + 1'b1;
        end
      end
      S_ENTER_B: begin
        if (ev_eq) begin
          if (b_cnt != '0) begin
            start = 1'b1; start_eq = 1'b1;
          end
        end else if (ev_op) begin
          if (b_cnt == '0) op_d = in_op;
          else begin
            start = 1'b1; pend_op_d = in_op;
          end
        end else if (ev_num && b_cnt < DW'(MAX_DIGITS)) begin
          b_d = append(b, d_ext); b_cnt_d = b_cnt + 1'b1;
        end
      end
      S_EXEC: begin
        if (op inside {OP_DIV, OP_MOD}) begin
          div_q_d = q_new; div_r_d = r_new; cnt_d = cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            wb     = 1'b1;
            wb_err = (b == '0);
`ifdef CALC_MOD_EN
            wb_val = (op == OP_MOD) ? r_new : q_new;
`else
            wb_val = q_new;
`endif
          end
        end else begin
          wb = 1'b1;
          case (op)
            OP_ADD:  begin wb_val = sum[WIDTH-1:0];  wb_err = sum[WIDTH]; end
            OP_SUB:  begin wb_val = a - b;           wb_err = (b > a); end
            OP_MUL:  begin wb_val = prod[WIDTH-1:0]; wb_err = |prod[2*WIDTH-1:WIDTH]; end
            default: begin wb_val = '0;              wb_err = 1'b0; end
          endcase
        end
      end
      S_ERROR: begin
        if (ev_num) begin
          error_d = 1'b0; a_d = d_ext; a_cnt_d = DW'(1); state_d = S_ENTER_A;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Operands are latched into a/b so the EXEC datapath never needs to know who triggered it.
    if (start) begin
      state_d = S_EXEC; eq_cmt_d = start_eq; a_d = x; b_d = y;
      div_q_d = x; div_r_d = '0; cnt_d = '0;
    end

    if (wb) begin
      if (wb_err) begin
        error_d = 1'b1; result_d = '0; result_temp_d = '0; state_d = S_ERROR;
      end else begin
        a_d = wb_val; result_temp_d = wb_val;
        if (eq_cmt) begin
          result_d = wb_val; rep_b_d = b; result_valid_d = 1'b1; state_d = S_DONE;
        end else begin
          op_d = pend_op; b_d = '0; b_cnt_d = '0; state_d = S_ENTER_B;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state        <= S_IDLE;
      op           <= OP_NONE;
      pend_op      <= OP_NONE;
      a            <= '0;
      b            <= '0;
      rep_b        <= '0;
      a_cnt        <= '0;
      b_cnt        <= '0;
      div_q        <= '0;
      div_r        <= '0;
      cnt          <= '0;
      eq_cmt       <= 1'b0;
      result       <= '0;
      result_temp  <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_d;
      op           <= op_d;
      pend_op      <= pend_op_d;
      a            <= a_d;
      b            <= b_d;
      rep_b        <= rep_b_d;
      a_cnt        <= a_cnt_d;
      b_cnt        <= b_cnt_d;
      div_q        <= div_q_d;
      div_r        <= div_r_d;
      cnt          <= cnt_d;
      eq_cmt       <= eq_cmt_d;
      result       <= result_d;
      result_temp  <= result_temp_d;
      result_valid <= result_valid_d;
      error        <= error_d;
    end
  end
endmodule

// File: tb/tb_fsm_calculator_nd.sv
// Randomized self-checking bench for fsm_calculator_nd against a keystroke-level calculator model.
module tb_fsm_calculator_nd;
  localparam int  W    = 16;
  localparam int  ND   = 4;
  localparam longint MAXV = (64'd1 << W) - 1;
  localparam int M_IDLE = 0, M_A = 1, M_B = 2, M_DONE = 3, M_ERR = 4;

  logic         clk = 1'b0;
  logic         clear_n, num_valid, op_valid, equal;
  logic [3:0]   button_num;
  logic [2:0]   button_op;
  logic [W-1:0] result_temp, result;
  logic         result_valid, busy, error;

  int n_checks = 0;
  int n_fail   = 0;

  int m_mode, m_a, m_b, m_acnt, m_bcnt, m_op, m_rep, m_res, m_tmp, m_err;

  always #5 clk = ~clk;

  fsm_calculator_nd #(.WIDTH(W), .MAX_DIGITS(ND)) dut (
    .clk(clk), .clear_n(clear_n), .num_valid(num_valid), .button_num(button_num),
    .op_valid(op_valid), .button_op(button_op), .equal(equal),
    .result_temp(result_temp), .result(result), .result_valid(result_valid),
    .busy(busy), .error(error)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode = M_IDLE; m_a = 0; m_b = 0; m_acnt = 0; m_bcnt = 0;
    m_op = 0; m_rep = 0; m_res = 0; m_tmp = 0; m_err = 0;
  endfunction

  function automatic bit op_legal(input int c);
`ifdef CALC_MOD_EN
    return c >= 1 && c <= 5;
`else
    return c >= 1 && c <= 4;
`endif
  endfunction

  function automatic void model_run(input int op, input int x, input int y, input bit commit,
                                    input int newop, output int lat, output int pulses);
    longint v;
    bit bad;
    v = 0; bad = 0;
    case (op)
      1: begin v = longint'(x) + y; bad = v > MAXV; end
      2: begin bad = y > x; v = bad ? 0 : longint'(x - y); end
      3: begin v = longint'(x) * y; bad = v > MAXV; end
      4: begin bad = (y == 0); v = bad ? 0 : longint'(x / y); end
      5: begin bad = (y == 0); v = bad ? 0 : longint'(x % y); end
      default: ;
    endcase
    lat = (op >= 4) ? W : 1;
    pulses = 0;
    if (bad) begin
      m_err = 1; m_res = 0; m_tmp = 0; m_mode = M_ERR;
    end else if (commit) begin
      m_res = int'(v); m_tmp = int'(v); m_a = int'(v); m_rep = y; pulses = 1; m_mode = M_DONE;
    end else begin
      m_a = int'(v); m_tmp = int'(v); m_op = newop; m_b = 0; m_bcnt = 0; m_mode = M_B;
    end
  endfunction

  function automatic void model_step(input bit nv, input int nd, input bit ov, input int oc,
                                     input bit ev, output int lat, output int pulses);
    lat = 0; pulses = 0;
    if (ev) begin
      if (m_mode == M_A) begin
        m_res = m_a; pulses = 1; m_mode = M_DONE;
      end else if (m_mode == M_B && m_bcnt > 0) model_run(m_op, m_a, m_b, 1, 0, lat, pulses);
      else if (m_mode == M_DONE && m_op != 0) model_run(m_op, m_res, m_rep, 1, 0, lat, pulses);
    end else if (ov) begin
      if (op_legal(oc)) begin
        if (m_mode == M_IDLE || m_mode == M_DONE || m_mode == M_A) begin
          if (m_mode != M_A) m_a = m_res;
          m_op = oc; m_b = 0; m_bcnt = 0; m_mode = M_B;
        end else if (m_mode == M_B) begin
          if (m_bcnt == 0) m_op = oc;
          else model_run(m_op, m_a, m_b, 0, oc, lat, pulses);
        end
      end
    end else if (nv && nd < 10) begin
      if (m_mode == M_A) begin
        if (m_acnt < ND) begin m_a = m_a * 10 + nd; m_acnt++; end
      end else if (m_mode == M_B) begin
        if (m_bcnt < ND) begin m_b = m_b * 10 + nd; m_bcnt++; end
      end else begin
        m_a = nd; m_acnt = 1; m_err = 0; m_mode = M_A;
      end
    end
  endfunction

  task automatic press(input bit nv, input int nd, input bit ov, input int oc, input bit ev);
    int lat, pulses, bcyc, rv;
    bit done;
    model_step(nv, nd, ov, oc, ev, lat, pulses);
    @(negedge clk);
    num_valid = nv; button_num = 4'(nd); op_valid = ov; button_op = 3'(oc); equal = ev;
    bcyc = 0; rv = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      num_valid = 0; op_valid = 0; equal = 0;
      rv += int'(result_valid);
      if (busy) begin
        bcyc++;
        // Strobes landing while busy must be dropped.
        if ($urandom_range(2) == 0) begin
          num_valid = 1'($urandom_range(1)); button_num = 4'($urandom_range(15));
          op_valid  = 1'($urandom_range(1)); button_op  = 3'($urandom_range(7));
          equal     = 1'($urandom_range(1));
        end
      end else done = 1;
    end
    check_eq("busy_timeout", done, 1);
    @(negedge clk);
    rv += int'(result_valid);
    check_eq("busy_cycles", bcyc, lat);
    check_eq("result_valid_pulses", rv, pulses);
    check_eq("result", result, m_res);
    check_eq("result_temp", result_temp, m_tmp);
    check_eq("error", error, m_err);
  endtask

  task automatic key_d(input int d);   press(1, d, 0, 0, 0); endtask
  task automatic key_op(input int c);  press(0, 0, 1, c, 0); endtask
  task automatic key_eq();             press(0, 0, 0, 0, 1); endtask

  task automatic do_reset();
    @(negedge clk);
    clear_n = 0; num_valid = 0; op_valid = 0; equal = 0;
    @(posedge clk); #1;
    check_eq("rst_result", result, 0);
    check_eq("rst_result_temp", result_temp, 0);
    check_eq("rst_result_valid", result_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_error", error, 0);
    @(negedge clk);
    clear_n = 1;
    model_reset();
  endtask

  initial begin
    int bcyc, rv, r;
    clear_n = 0; num_valid = 0; op_valid = 0; equal = 0; button_num = '0; button_op = '0;
    model_reset();
    do_reset();

    key_d(1); key_d(2); key_op(1); key_d(3); key_d(4); key_eq();
    check_eq("add_46", result, 46);
    key_d(1); key_d(2); key_d(5); key_op(3); key_d(4); key_op(2);
    check_eq("chain_tmp_500", result_temp, 500);
    key_d(1); key_d(0); key_d(0); key_eq();
    check_eq("chain_400", result, 400);
    key_d(7); key_d(8); key_d(1); key_d(2); key_d(5);
    key_op(4); key_d(4); key_eq();
    check_eq("div_1953", result, 1953);
    key_eq();
    check_eq("repeat_488", result, 488);
    key_d(5); key_op(4); key_d(0); key_eq();
    check_eq("div0_error", error, 1);
    check_eq("div0_result", result, 0);
    key_d(3); key_op(2); key_d(9); key_eq();
    check_eq("sub_borrow_error", error, 1);
    for (int i = 0; i < 4; i++) key_d(9);
    key_op(3);
    for (int i = 0; i < 4; i++) key_d(9);
    key_eq();
    check_eq("mul_ovf_error", error, 1);
    key_d(2);
    check_eq("digit_clears_error", error, 0);
    key_op(1); key_d(1); key_eq();
    check_eq("after_error_3", result, 3);

    // Reset on the 5th busy cycle of a division.
    do_reset();
    for (int i = 0; i < 4; i++) key_d(9);
    key_op(4); key_d(7);
    @(negedge clk); equal = 1;
    bcyc = 0;
    for (int i = 0; i < 40 && bcyc < 5; i++) begin
      @(negedge clk); equal = 0;
      if (busy) bcyc++;
    end
    check_eq("div_busy_before_abort", bcyc, 5);
    clear_n = 0;
    @(posedge clk); #1;
    check_eq("abort_result", result, 0);
    check_eq("abort_result_temp", result_temp, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_error", error, 0);
    check_eq("abort_result_valid", result_valid, 0);
    @(negedge clk); clear_n = 1;
    rv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); rv += int'(result_valid);
    end
    check_eq("abort_no_result_valid", rv, 0);
    model_reset();
    key_d(3); key_eq();
    check_eq("abort_then_digit", result, 3);

    do_reset();
`ifdef CALC_MOD_EN
    key_d(1); key_d(7); key_op(5); key_d(5); key_eq();
    check_eq("mod_17_5", result, 2);
`else
    key_d(1); key_d(7); key_op(5); key_eq();
    check_eq("mod_ignored_17", result, 17);
`endif

    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(99));
      if (r < 50)      key_d(int'($urandom_range(11)));
      else if (r < 68) key_op(int'($urandom_range(7)));
      else if (r < 85) key_eq();
      else if (r < 99) press(1'($urandom_range(1)), int'($urandom_range(15)),
                             1'($urandom_range(1)), int'($urandom_range(7)), 1'($urandom_range(1)));
      else do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
